// File: rtl/morph_pkg.sv
// Shared constants and helpers for the K x K binary morphology stage.
package morph_pkg;

    localparam logic MODE_DILATE = 1'b0;
    localparam logic MODE_ERODE  = 1'b1;
    localparam int   MORPH_LAT   = 3;

    // Value that leaves the selected reduction unchanged: 0 for OR, 1 for AND
    function automatic logic pad_bit(input logic m);
        return (m == MODE_ERODE);
    endfunction

endpackage

// File: rtl/morph_kxk_linebuf.sv
// One video line of 1-bit pixels: synchronous write, asynchronous read at the same address.
module morph_linebuf #(
    parameter int DEPTH = 1280,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          video_clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          wdata,
    output logic          rdata
);

    logic mem [DEPTH];

    always_ff @(posedge video_clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    // The read returns last line's pixel before this cycle's write replaces it
    assign rdata = mem[addr];

endmodule

// File: rtl/morph_kxk.sv
// K x K binary dilate/erode with internal line buffers and a fixed 3-clock latency.
// Optional foreground pixel counter output fg_cnt when MORPH_FG_CNT_EN is defined.
module morph_kxk
    import morph_pkg::*;
#(
    parameter int IMG_WIDTH = 1280,
    parameter int KSIZE     = 3,
    parameter int COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic        video_clk,
    input  logic        rst_n,
    input  logic        in_de,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic        in_bin,
    input  logic        mode,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs,
    output logic [23:0] out_data
`ifdef MORPH_FG_CNT_EN
    ,
    output logic [31:0] fg_cnt
`endif
);

    localparam int ROW_W = $clog2(KSIZE);

    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
        $error("morph_kxk: KSIZE must be 3 or 5");
    end

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             de_d;
    logic             vs_d;
    logic             mode_q;
    logic             de_fall;
    logic             vs_rise;

    assign de_fall = de_d & ~in_de;
    assign vs_rise = in_vs & ~vs_d;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            de_d   <= 1'b0;
            vs_d   <= 1'b0;
            mode_q <= MODE_DILATE;
        end else begin
            de_d <= in_de;
            vs_d <= in_vs;
            if (vs_rise)
                mode_q <= mode;
            if (in_de) begin
                if (col != COL_W'(IMG_WIDTH - 1))
                    col <= col + 1'b1;
            end else if (de_fall) begin
                col <= '0;
            end
            if (vs_rise)
                row <= '0;
            else if (de_fall && row != ROW_W'(KSIZE - 1))
                row <= row + 1'b1;
        end
    end

    // Buffer j holds the line j+1 above; each buffer feeds the next one up the chain
    logic [KSIZE-2:0] lb_q;

    for (genvar j = 0; j < KSIZE - 1; j++) begin : g_lb
        logic wbit;
        if (j == 0) begin : g_first
            assign wbit = in_bin;
        end else begin : g_next
            assign wbit = lb_q[j-1];
        end
        morph_linebuf #(
            .DEPTH (IMG_WIDTH),
            .AW    (COL_W)
        ) u_lb (
            .video_clk (video_clk),
            .we        (in_de),
            .addr      (col),
            .wdata     (wbit),
            .rdata     (lb_q[j])
        );
    end

    logic [KSIZE-1:0]              new_col;
    logic [KSIZE-1:0][KSIZE-2:0]   hist;
    logic [KSIZE-1:0][KSIZE-1:0]   win_c;
    logic [KSIZE-1:0][KSIZE-1:0]   win1;
    logic                          full_c;
    logic                          full1;
    logic                          full2;
    logic                          mode1;
    logic                          mode2;
    logic                          pad;
    logic [KSIZE-1:0]              rowred_c;
    logic [KSIZE-1:0]              rowred2;
    logic                          res_c;
    logic [MORPH_LAT-1:0]          de_p;
    logic [MORPH_LAT-1:0]          hs_p;
    logic [MORPH_LAT-1:0]          vs_p;

    // Elements not yet written this frame or this line take the pad value,
    // so older frame/line contents never enter the reduction
    always_comb begin
        pad        = pad_bit(mode_q);
        new_col    = '0;
        new_col[0] = in_bin;
        for (int r = 1; r < KSIZE; r++)
            new_col[r] = lb_q[r-1];
        win_c = '0;
        for (int r = 0; r < KSIZE; r++) begin
            win_c[r][0] = (int'(row) >= r) ? new_col[r] : pad;
            for (int k = 1; k < KSIZE; k++)
                win_c[r][k] = (int'(col) >= k && int'(row) >= r) ? hist[r][k-1] : pad;
        end
        full_c = (int'(col) >= KSIZE - 1) && (int'(row) >= KSIZE - 1);
    end

    always_comb begin
        rowred_c = '0;
        for (int r = 0; r < KSIZE; r++)
            rowred_c[r] = (mode1 == MODE_ERODE) ? &win1[r] : |win1[r];
        res_c = (mode2 == MODE_ERODE) ? &rowred2 : |rowred2;
    end

    // Windows not fully inside the image (top/left border) are reported as background
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            hist     <= '0;
            win1     <= '0;
            full1    <= 1'b0;
            mode1    <= MODE_DILATE;
            rowred2  <= '0;
            full2    <= 1'b0;
            mode2    <= MODE_DILATE;
            de_p     <= '0;
            hs_p     <= '0;
            vs_p     <= '0;
            out_data <= '0;
        end else begin
            if (in_de) begin
                for (int r = 0; r < KSIZE; r++)
                    hist[r] <= {hist[r][KSIZE-3:0], new_col[r]};
            end
            win1     <= win_c;
            full1    <= full_c;
            mode1    <= mode_q;
            rowred2  <= rowred_c;
            full2    <= full1;
            mode2    <= mode1;
            de_p     <= {de_p[MORPH_LAT-2:0], in_de};
            hs_p     <= {hs_p[MORPH_LAT-2:0], in_hs};
            vs_p     <= {vs_p[MORPH_LAT-2:0], in_vs};
            out_data <= {24{de_p[MORPH_LAT-2] & full2 & res_c}};
        end
    end

    assign out_de = de_p[MORPH_LAT-1];
    assign out_hs = hs_p[MORPH_LAT-1];
    assign out_vs = vs_p[MORPH_LAT-1];

`ifdef MORPH_FG_CNT_EN
    logic [31:0] fg_acc;
    logic        out_vs_d;

    // Per-frame foreground total, published at the start of the next output frame
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            fg_acc   <= '0;
            fg_cnt   <= '0;
            out_vs_d <= 1'b0;
        end else begin
            out_vs_d <= out_vs;
            if (out_vs && !out_vs_d) begin
                fg_cnt <= fg_acc;
                fg_acc <= '0;
            end else if (out_de && out_data[0]) begin
                fg_acc <= fg_acc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_morph_kxk.sv
// Directed bench for morph_kxk: 3x3 kernel, 8-pixel lines, 5-line frames.
module tb_morph_kxk;

    logic        video_clk = 1'b0;
    logic        rst_n;
    logic        in_de;
    logic        in_hs;
    logic        in_vs;
    logic        in_bin;
    logic        mode;
    logic        out_de;
    logic        out_hs;
    logic        out_vs;
    logic [23:0] out_data;
`ifdef MORPH_FG_CNT_EN
    logic [31:0] fg_cnt;
`endif

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          in_first;
    int          out_first;
    int          cap_n;
    logic [23:0] cap [64];
    logic        img [5][8];

    morph_kxk #(
        .IMG_WIDTH (8),
        .KSIZE     (3)
    ) dut (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .in_de     (in_de),
        .in_hs     (in_hs),
        .in_vs     (in_vs),
        .in_bin    (in_bin),
        .mode      (mode),
        .out_de    (out_de),
        .out_hs    (out_hs),
        .out_vs    (out_vs),
        .out_data  (out_data)
`ifdef MORPH_FG_CNT_EN
        ,
        .fg_cnt    (fg_cnt)
`endif
    );

    always #5 video_clk = ~video_clk;

    always @(posedge video_clk) cyc <= cyc + 1;

    // Drives one frame from img (mode m0, switched to m1 mid-line sw_line) and captures out_data
    task automatic run_frame(input logic m0, input logic m1, input int sw_line);
        cap_n = 0;
        for (int i = 0; i < 64; i++) cap[i] = 'x;
        fork
            begin
                in_vs = 1'b1;
                mode  = m0;
                repeat (2) @(negedge video_clk);
                in_vs = 1'b0;
                repeat (2) @(negedge video_clk);
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        in_de  = 1'b1;
                        in_bin = img[r][c];
                        if (r == sw_line && c == 4) mode = m1;
                        if (r == 0 && c == 0) in_first = cyc;
                        @(negedge video_clk);
                    end
                    in_de  = 1'b0;
                    in_bin = 1'b0;
                    @(negedge video_clk);
                end
                repeat (4) @(negedge video_clk);
            end
            begin
                repeat (53) begin
                    @(negedge video_clk);
                    if (out_de) begin
                        if (cap_n == 0) out_first = cyc;
                        if (cap_n < 64) cap[cap_n] = out_data;
                        cap_n++;
                    end
                end
            end
        join
    endtask

    task automatic fill_img(input logic v);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0; in_bin = 1'b0; mode = 1'b0;
        repeat (3) @(negedge video_clk);
        n_cmp++; if (out_de !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_de got %b expected 0", out_de); end
        n_cmp++; if (out_hs !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hs got %b expected 0", out_hs); end
        n_cmp++; if (out_vs !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vs got %b expected 0", out_vs); end
        n_cmp++; if (out_data !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_data got %h expected 000000", out_data); end
`ifdef MORPH_FG_CNT_EN
        n_cmp++; if (fg_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_fg got %0d expected 0", fg_cnt); end
`endif
        rst_n = 1'b1;
        @(negedge video_clk);
    endtask

    task automatic test_dilate_pixel(input string tag);
        logic [23:0] exp;
        fill_img(1'b0);
        img[2][3] = 1'b1;
        run_frame(1'b0, 1'b0, -1);
        n_cmp++; if (cap_n !== 40) begin n_fail++; $display("[TB] FAIL %s_count got %0d expected 40", tag, cap_n); end
        n_cmp++; if (out_first - in_first !== 3) begin n_fail++; $display("[TB] FAIL %s_latency got %0d expected 3", tag, out_first - in_first); end
        for (int i = 0; i < 40; i++) begin
            int r = i / 8;
            int c = i % 8;
            exp = {24{(r >= 2 && r <= 4 && c >= 3 && c <= 5)}};
            n_cmp++;
            if (cap[i] !== exp) begin n_fail++; $display("[TB] FAIL %s[%0d,%0d] got %h expected %h", tag, r, c, cap[i], exp); end
        end
`ifdef MORPH_FG_CNT_EN
        in_vs = 1'b1;
        repeat (2) @(negedge video_clk);
        in_vs = 1'b0;
        repeat (5) @(negedge video_clk);
        n_cmp++; if (fg_cnt !== 32'd9) begin n_fail++; $display("[TB] FAIL %s_fg got %0d expected 9", tag, fg_cnt); end
`endif
    endtask

    task automatic test_erode_ones;
        logic [23:0] exp;
        fill_img(1'b1);
        run_frame(1'b1, 1'b1, -1);
        n_cmp++; if (cap_n !== 40) begin n_fail++; $display("[TB] FAIL erode_ones_count got %0d expected 40", cap_n); end
        for (int i = 0; i < 40; i++) begin
            int r = i / 8;
            int c = i % 8;
            exp = {24{(r >= 2 && c >= 2)}};
            n_cmp++;
            if (cap[i] !== exp) begin n_fail++; $display("[TB] FAIL erode_ones[%0d,%0d] got %h expected %h", r, c, cap[i], exp); end
        end
    endtask

    task automatic test_erode_hole;
        logic [23:0] exp;
        fill_img(1'b1);
        img[3][4] = 1'b0;
        run_frame(1'b1, 1'b1, -1);
        for (int i = 0; i < 40; i++) begin
            int r = i / 8;
            int c = i % 8;
            exp = {24{(r >= 2 && c >= 2 && !(r >= 3 && c >= 4 && c <= 6))}};
            n_cmp++;
            if (cap[i] !== exp) begin n_fail++; $display("[TB] FAIL erode_hole[%0d,%0d] got %h expected %h", r, c, cap[i], exp); end
        end
    endtask

    task automatic test_mode_change;
        logic [23:0] exp;
        fill_img(1'b0);
        img[2][3] = 1'b1;
        run_frame(1'b0, 1'b1, 2);
        for (int i = 0; i < 40; i++) begin
            int r = i / 8;
            int c = i % 8;
            exp = {24{(r >= 2 && r <= 4 && c >= 3 && c <= 5)}};
            n_cmp++;
            if (cap[i] !== exp) begin n_fail++; $display("[TB] FAIL mode_hold[%0d,%0d] got %h expected %h", r, c, cap[i], exp); end
        end
        fill_img(1'b1);
        run_frame(1'b1, 1'b1, -1);
        for (int i = 0; i < 40; i++) begin
            int r = i / 8;
            int c = i % 8;
            exp = {24{(r >= 2 && c >= 2)}};
            n_cmp++;
            if (cap[i] !== exp) begin n_fail++; $display("[TB] FAIL mode_next[%0d,%0d] got %h expected %h", r, c, cap[i], exp); end
        end
    endtask

    task automatic test_stale;
        logic [23:0] exp;
        fill_img(1'b1);
        run_frame(1'b0, 1'b0, -1);
        for (int i = 0; i < 40; i++) begin
            int r = i / 8;
            int c = i % 8;
            exp = {24{(r >= 2 && c >= 2)}};
            n_cmp++;
            if (cap[i] !== exp) begin n_fail++; $display("[TB] FAIL dilate_ones[%0d,%0d] got %h expected %h", r, c, cap[i], exp); end
        end
        fill_img(1'b0);
        run_frame(1'b0, 1'b0, -1);
        n_cmp++; if (cap_n !== 40) begin n_fail++; $display("[TB] FAIL stale_count got %0d expected 40", cap_n); end
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (cap[i] !== 24'h0) begin n_fail++; $display("[TB] FAIL stale[%0d,%0d] got %h expected 000000", i / 8, i % 8, cap[i]); end
        end
    endtask

    task automatic test_reset_mid;
        in_vs = 1'b1;
        mode  = 1'b0;
        repeat (2) @(negedge video_clk);
        in_vs = 1'b0;
        repeat (2) @(negedge video_clk);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r == 3 && c == 6) break;
                in_de  = 1'b1;
                in_bin = 1'b1;
                @(negedge video_clk);
            end
            if (r < 3) begin
                in_de = 1'b0;
                @(negedge video_clk);
            end
        end
        n_cmp++; if (out_de !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_de got %b expected 1", out_de); end
        n_cmp++; if (out_data !== 24'hFFFFFF) begin n_fail++; $display("[TB] FAIL pre_reset_data got %h expected ffffff", out_data); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_de !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_de got %b expected 0", out_de); end
        n_cmp++; if (out_data !== 24'h0) begin n_fail++; $display("[TB] FAIL midreset_data got %h expected 000000", out_data); end
        n_cmp++; if (out_vs !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_vs got %b expected 0", out_vs); end
        in_de  = 1'b0;
        in_bin = 1'b0;
        repeat (2) @(negedge video_clk);
        rst_n = 1'b1;
        @(negedge video_clk);
    endtask

    initial begin
        test_reset();
        test_dilate_pixel("dilate_px");
        test_erode_ones();
        test_erode_hole();
        test_mode_change();
        test_stale();
        test_reset_mid();
        test_dilate_pixel("recover_px");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
